// File: rtl/lcd_bus_arbiter.sv
// Two-requester, write-only HD44780-style LCD bus arbiter with round-robin grant.
// Optional power-on command sequence (0x38, 0x0C, 0x01, 0x06) enabled by LCD_INIT_SEQ_EN.
module lcd_bus_arbiter #(
    parameter int WAIT_CYC     = 2,
    parameter int CLR_WAIT_CYC = 4
) (
    input  logic       clk_1024,
    input  logic       reset_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       rs0,
    input  logic       rs1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] lcd_data,
    output logic       lcd_E,
    output logic       lcd_RS,
    output logic       lcd_RW,
    output logic       busy,
    output logic       init_done
);

`ifdef LCD_INIT_SEQ_EN
    typedef enum logic [2:0] {
        ST_INIT, ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_WAIT
    } state_t;
    localparam state_t RESET_STATE = ST_INIT;

    logic [1:0] r_init_idx;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_WAIT
    } state_t;
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    localparam logic [3:0] L_WAIT_LOAD = 4'(WAIT_CYC - 1);
    localparam logic [3:0] L_CLR_LOAD  = 4'(CLR_WAIT_CYC - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_last_grant;
    logic       r_grant;

    logic w_pick1;
    logic w_can_grant;
    logic w_long_wait;

    // Requester 1 wins alone, or on a tie when requester 0 was served last.
    assign w_pick1     = req1 && (!req0 || !r_last_grant);
    assign w_can_grant = (r_state == ST_IDLE) && init_done && !ack0 && !ack1
                         && (req0 || req1);
    assign w_long_wait = !lcd_RS && ((lcd_data == 8'h01) || (lcd_data == 8'h02));
    assign lcd_RW      = 1'b0;

    always_ff @(posedge clk_1024 or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= RESET_STATE;
            r_cnt        <= 4'd0;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            lcd_data     <= 8'h00;
            lcd_RS       <= 1'b0;
            lcd_E        <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            busy         <= 1'b0;
            init_done    <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
            r_init_idx   <= 2'd0;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
`ifndef LCD_INIT_SEQ_EN
            init_done <= 1'b1;
`endif
            case (r_state)
`ifdef LCD_INIT_SEQ_EN
                ST_INIT: begin
                    lcd_data <= init_byte(r_init_idx);
                    lcd_RS   <= 1'b0;
                    busy     <= 1'b1;
                    r_state  <= ST_SETUP;
                end
`endif
                ST_IDLE: begin
                    if (w_can_grant) begin
                        r_grant      <= w_pick1;
                        r_last_grant <= w_pick1;
                        lcd_data     <= w_pick1 ? data1 : data0;
                        lcd_RS       <= w_pick1 ? rs1 : rs0;
                        busy         <= 1'b1;
                        r_state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    lcd_E   <= 1'b1;
                    r_state <= ST_PULSE;
                end
                ST_PULSE: begin
                    lcd_E   <= 1'b0;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    r_cnt   <= w_long_wait ? L_CLR_LOAD : L_WAIT_LOAD;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
                        if (!init_done) begin
                            if (r_init_idx == 2'd3) begin
                                init_done <= 1'b1;
                            end else begin
                                r_init_idx <= r_init_idx + 2'd1;
                                busy       <= 1'b1;
                                r_state    <= ST_INIT;
                            end
                        end else begin
                            ack0 <= !r_grant;
                            ack1 <= r_grant;
                        end
`else
                        ack0 <= !r_grant;
                        ack1 <= r_grant;
`endif
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter (default build): vector table plus
// hand-written sequences for late requests, async reset abort and back-to-back ties.
module tb_lcd_bus_arbiter;

    logic       clk_1024 = 1'b0;
    logic       reset_n  = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, rs0 = 1'b0, rs1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       ack0, ack1, lcd_E, lcd_RS, lcd_RW, busy, init_done;
    logic [7:0] lcd_data;

    int n_tests = 0;
    int n_fail  = 0;

    lcd_bus_arbiter #(.WAIT_CYC(2), .CLR_WAIT_CYC(4)) dut (
        .clk_1024 (clk_1024),
        .reset_n  (reset_n),
        .req0     (req0),
        .req1     (req1),
        .rs0      (rs0),
        .rs1      (rs1),
        .data0    (data0),
        .data1    (data1),
        .ack0     (ack0),
        .ack1     (ack1),
        .lcd_data (lcd_data),
        .lcd_E    (lcd_E),
        .lcd_RS   (lcd_RS),
        .lcd_RW   (lcd_RW),
        .busy     (busy),
        .init_done(init_done)
    );

    always #5 clk_1024 = ~clk_1024;

    typedef struct {
        logic       r0, r1, s0, s1;
        logic [7:0] d0, d1;
        logic       sel;
        logic [7:0] ed;
        logic       ers;
        int         wt;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic r1, input logic s0, input logic s1,
                         input logic [7:0] d0, input logic [7:0] d1);
        req0 = r0; req1 = r1; rs0 = s0; rs1 = s1; data0 = d0; data1 = d1;
    endtask

    initial begin
        // {req0, req1, rs0, rs1, data0, data1, winner, exp data, exp rs, wait cycles}
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h41, 8'h42, 1'b0, 8'h41, 1'b1, 2};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h41, 8'h42, 1'b1, 8'h42, 1'b1, 2};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h32, 8'h00, 1'b0, 8'h32, 1'b1, 2};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h38, 1'b1, 8'h38, 1'b0, 2};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 4};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 8'h02, 1'b0, 4};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 8'h01, 1'b1, 2};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 8'h99, 1'b1, 8'h99, 1'b1, 2};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 1'b1, 8'h03, 1'b0, 2};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 8'h99, 1'b0, 8'h02, 1'b0, 4};

        // Reset values
        repeat (3) @(negedge clk_1024);
        chk("rst_E", {15'd0, lcd_E}, 16'd0);
        chk("rst_RW", {15'd0, lcd_RW}, 16'd0);
        chk("rst_RS", {15'd0, lcd_RS}, 16'd0);
        chk("rst_data", {8'd0, lcd_data}, 16'h0000);
        chk("rst_acks", {14'd0, ack1, ack0}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_init_done", {15'd0, init_done}, 16'd0);
        reset_n = 1'b1;
        #1 chk("init_done_pre_edge", {15'd0, init_done}, 16'd0);
        @(negedge clk_1024);
        chk("init_done_post_edge", {15'd0, init_done}, 16'd1);
        chk("busy_after_release", {15'd0, busy}, 16'd0);

        // Table-driven single transfers
        for (int i = 0; i < 10; i++) begin
            logic [1:0] exp_ack;
            exp_ack = vecs[i].sel ? 2'b10 : 2'b01;
            drive(vecs[i].r0, vecs[i].r1, vecs[i].s0, vecs[i].s1, vecs[i].d0, vecs[i].d1);
            @(negedge clk_1024);
            chk("grant_data", {8'd0, lcd_data}, {8'd0, vecs[i].ed});
            chk("grant_rs", {15'd0, lcd_RS}, {15'd0, vecs[i].ers});
            chk("grant_E", {15'd0, lcd_E}, 16'd0);
            chk("grant_busy", {15'd0, busy}, 16'd1);
            @(negedge clk_1024);
            chk("pulse_E", {15'd0, lcd_E}, 16'd1);
            @(negedge clk_1024);
            chk("hold_E", {15'd0, lcd_E}, 16'd0);
            chk("hold_data", {8'd0, lcd_data}, {8'd0, vecs[i].ed});
            for (int k = 3; k < 3 + vecs[i].wt; k++) begin
                @(negedge clk_1024);
                chk("wait_acks", {14'd0, ack1, ack0}, 16'd0);
                chk("wait_E", {15'd0, lcd_E}, 16'd0);
            end
            @(negedge clk_1024);
            chk("ack", {14'd0, ack1, ack0}, {14'd0, exp_ack});
            chk("ack_busy", {15'd0, busy}, 16'd0);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            @(negedge clk_1024);
            chk("ack_one_cycle", {14'd0, ack1, ack0}, 16'd0);
            chk("idle_data_kept", {8'd0, lcd_data}, {8'd0, vecs[i].ed});
            chk("idle_rs_kept", {15'd0, lcd_RS}, {15'd0, vecs[i].ers});
            $display("[TB] vec %0d: data=%h rs=%b winner=%0d wait=%0d", i,
                     vecs[i].ed, vecs[i].ers, vecs[i].sel, vecs[i].wt);
            @(negedge clk_1024);
        end

        // Late request from requester 1 during requester 0's pulse
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 8'h00);
        @(negedge clk_1024);                       // N
        chk("late_grant_data", {8'd0, lcd_data}, 16'h0055);
        @(negedge clk_1024);                       // N+1
        chk("late_pulse_E", {15'd0, lcd_E}, 16'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hAA, 8'h66);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk_1024);
            chk("late_data_stable", {8'd0, lcd_data}, 16'h0055);
            chk("late_no_ack", {14'd0, ack1, ack0}, 16'd0);
        end
        @(negedge clk_1024);                       // N+5
        chk("late_ack0", {14'd0, ack1, ack0}, 16'd1);
        req0 = 1'b0;
        @(negedge clk_1024);                       // N+6
        chk("late_no_grant_in_ack", {8'd0, lcd_data}, 16'h0055);
        chk("late_idle_busy", {15'd0, busy}, 16'd0);
        @(negedge clk_1024);                       // N+7
        chk("late_grant1_data", {8'd0, lcd_data}, 16'h0066);
        chk("late_grant1_busy", {15'd0, busy}, 16'd1);
        repeat (4) @(negedge clk_1024);            // N+11
        chk("late_no_ack_early", {14'd0, ack1, ack0}, 16'd0);
        @(negedge clk_1024);                       // N+12
        chk("late_ack1", {14'd0, ack1, ack0}, 16'd2);
        $display("[TB] late req1: req0 0x55 then req1 0x66");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clk_1024);

        // Asynchronous reset while E is high
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h77, 8'h00);
        @(negedge clk_1024);
        @(negedge clk_1024);
        chk("abort_E_before", {15'd0, lcd_E}, 16'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_E_async", {15'd0, lcd_E}, 16'd0);
        chk("abort_data", {8'd0, lcd_data}, 16'h0000);
        chk("abort_busy", {15'd0, busy}, 16'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_1024);
            chk("abort_no_ack", {14'd0, ack1, ack0}, 16'd0);
        end
        reset_n = 1'b1;
        @(negedge clk_1024);
        chk("abort_init_done", {15'd0, init_done}, 16'd1);
        $display("[TB] reset abort during pulse of 0x77");

        // Both held continuously after reset: round-robin from a fresh last_grant
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h41, 8'h42);
        for (int c = 0; c < 28; c++) begin
            @(negedge clk_1024);
            if (c % 7 == 0)
                chk("rr_data", {8'd0, lcd_data}, ((c / 7) % 2 == 0) ? 16'h0041 : 16'h0042);
            if (c % 7 == 5)
                chk("rr_ack", {14'd0, ack1, ack0}, ((c / 7) % 2 == 0) ? 16'd1 : 16'd2);
            if (c % 7 == 1)
                chk("rr_E", {15'd0, lcd_E}, 16'd1);
        end
        $display("[TB] round-robin stream 41 42 41 42");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk_1024);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter WAIT_CYC, default 2: post-strobe wait cycles for ordinary transfers (legal range 1-15).
REQ-003 Parameter CLR_WAIT_CYC, default 4: post-strobe wait cycles for commands 0x01/0x02 with RS=0 (legal range 1-15).
REQ-004 clk_1024  in  1  system clock, 1024 Hz.
REQ-005 reset_n  in  1  asynchronous reset, active low.
REQ-006 req0 / req1  in  1  transfer request, requester 0 / 1.
REQ-007 rs0 / rs1  in  1  register select (1 = data, 0 = command).
REQ-008 data0 / data1  in  8  byte to write.
REQ-009 ack0 / ack1  out  1  one-cycle transfer-complete pulse.
REQ-010 lcd_data  out  8  LCD data bus.
REQ-011 lcd_E  out  1  LCD enable strobe.
REQ-012 lcd_RS  out  1  LCD register select.
REQ-013 lcd_RW  out  1  LCD read/write, constant 0 (write only).
REQ-014 busy  out  1  high in any state other than IDLE, and during the init sequence.
REQ-015 init_done  out  1  high once the LCD is ready for requester traffic.

Function
REQ-016 States: INIT (macro only), IDLE, SETUP, PULSE, HOLD, WAIT. All outputs are registered.
REQ-017 Grant rule: when in IDLE with init_done=1 and ack0=ack1=0, a clock edge with req asserted latches that requester's rs/data onto lcd_RS/lcd_data and enters SETUP.
REQ-018 Arbitration: with a single request, that requester is granted. With both requesting, the requester not granted last wins (round-robin). last_grant resets to 1, so requester 0 wins the first tie.
REQ-019 Sequencing: SETUP lasts 1 cycle with E=0. PULSE lasts 1 cycle with E=1. HOLD lasts 1 cycle with E=0. lcd_data and lcd_RS are held stable throughout.
REQ-020 WAIT lasts CLR_WAIT_CYC cycles when RS=0 and data is 0x01 or 0x02, otherwise WAIT_CYC cycles, counted by a 4-bit down-counter.
REQ-021 On leaving WAIT, the granted requester's ack is high for exactly one cycle while in IDLE. No grant occurs in that cycle.
REQ-022 Latency with default parameters: grant edge N; E high during N+1..N+2; ack high during N+5..N+6; earliest next grant at edge N+7.
REQ-023 Requesters SHALL hold req/rs/data stable until ack. Changes after the grant edge do not affect the transfer in progress.
REQ-024 A requester that keeps req high after its ack is re-granted only under the round-robin rule.
REQ-025 lcd_data and lcd_RS retain the last transferred values in IDLE.

Reset
REQ-026 While reset_n=0, the outputs SHALL be: lcd_E=0, lcd_RW=0, lcd_RS=0, lcd_data=0x00, ack0=ack1=0, busy=0, init_done=0.
REQ-027 While reset_n=0, the internal state SHALL be: state=IDLE (or INIT when the macro is defined), counters=0, last_grant=1.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer immediately: E drops asynchronously and no ack is issued.

Configuration
REQ-029 Macro LCD_INIT_SEQ_EN defined: after reset, the block issues command bytes 0x38, 0x0C, 0x01, 0x06 (RS=0), each using the full SETUP/PULSE/HOLD/WAIT sequence. During this sequence busy=1 and requests are ignored. init_done rises in the cycle after the last WAIT ends.
REQ-030 Macro LCD_INIT_SEQ_EN undefined: no INIT state exists. init_done rises at the first clock edge after reset release, and IDLE grants from the next edge.

Verification
REQ-031 Macro on, reset release, no requests -> four E pulses carrying 0x38, 0x0C, 0x01, 0x06 with RS=0. A 4-cycle wait follows 0x01. Then init_done=1 and busy=0.
REQ-032 req0=1, rs0=1, data0=0x32 in IDLE -> lcd_RS=1 and lcd_data=0x32 from edge N, E high for 1 cycle at N+1, ack0 high for one cycle at N+5, ack1 stays 0.
REQ-033 req0 and req1 held high continuously with data0=0x41, data1=0x42 -> lcd_data sequence 0x41, 0x42, 0x41, 0x42, with ack0 and ack1 alternating.
REQ-034 req1 asserted during requester 0's PULSE -> requester 0 completes unchanged, then requester 1 is granted at the first legal IDLE edge after ack0.
REQ-035 reset_n pulled low while lcd_E=1 -> lcd_E=0 with no clock edge, no ack. After release (macro off), a new req0 completes normally.
REQ-036 rs0=0, data0=0x01 -> WAIT lasts 4 cycles, so ack0 rises 2 cycles later than for data0=0x38.
